b2s_tx_gen2: RTL and testbench

B2S_TX_GEN2 -- requirements
Module: b2s_tx_gen2

---
 rtl/b2s_tx_gen2.sv | 202 ++++++++++++++++++++
 tb/tb_b2s_tx_gen2.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/b2s_tx_gen2.sv
// Single-wire frame transmitter: optional reset/presence prefix, start sequence,
// pulse-width coded data bits, then a released-line window that samples one reply bit.
module b2s_tx_gen2 #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned CNT_W     = 14,
   parameter int unsigned MSB_FIRST = 0,
   parameter int unsigned T_INIT    = 20,
   parameter int unsigned T_START_L = 20,
   parameter int unsigned T_START_H = 20,
   parameter int unsigned T_ONE_L   = 18,
   parameter int unsigned T_ONE_H   = 149,
   parameter int unsigned T_ZERO_L  = 136,
   parameter int unsigned T_ZERO_H  = 31,
   parameter int unsigned T_REL     = 150,
   parameter int unsigned T_SAMP    = 75,
   parameter int unsigned T_RST_L   = 1280,
   parameter int unsigned T_PD_WAIT = 70,
   parameter int unsigned T_PD_WIN  = 400,
   parameter int unsigned T_RECOV   = 600
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             rst_req,
   output logic             din_ready,
   input  logic             b2s_din,
   output logic             b2s_dout,
   output logic             b2s_oe,
   output logic             busy,
   output logic             done,
   output logic             presence,
   output logic             presence_err,
   output logic             rx_bit
);

   localparam int unsigned BW = $clog2(WIDTH + 1);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_RST_L   = 4'd1;
   localparam logic [3:0] S_PD_WAIT = 4'd2;
   localparam logic [3:0] S_PD_WIN  = 4'd3;
   localparam logic [3:0] S_RECOV   = 4'd4;
   localparam logic [3:0] S_INIT_H  = 4'd5;
   localparam logic [3:0] S_START_L = 4'd6;
   localparam logic [3:0] S_START_H = 4'd7;
   localparam logic [3:0] S_BIT_L   = 4'd8;
   localparam logic [3:0] S_BIT_H   = 4'd9;
   localparam logic [3:0] S_REL     = 4'd10;
   localparam logic [3:0] S_DONE    = 4'd11;

   localparam logic [BW-1:0] FIRST_IDX = (MSB_FIRST != 0) ? BW'(WIDTH - 1) : '0;
   localparam logic [BW-1:0] LAST_IDX  = (MSB_FIRST != 0) ? '0 : BW'(WIDTH - 1);

   logic [3:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [BW-1:0]    bit_idx_q, bit_idx_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             rst_req_q, rst_req_d;
   logic             presence_q, presence_d;
   logic             presence_err_q, presence_err_d;
   logic             rx_bit_q, rx_bit_d;

   logic             cur_bit;
   logic [CNT_W-1:0] len;
   logic             cnt_last;

   always_comb begin
      cur_bit = 1'b0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (bit_idx_q == BW'(i)) cur_bit = data_q[i];
      end
   end

   // Duration of the current state; IDLE and DONE are untimed.
   always_comb begin
      len = CNT_W'(1);
      case (state_q)
         S_RST_L:   len = CNT_W'(T_RST_L);
         S_PD_WAIT: len = CNT_W'(T_PD_WAIT);
         S_PD_WIN:  len = CNT_W'(T_PD_WIN);
         S_RECOV:   len = CNT_W'(T_RECOV);
         S_INIT_H:  len = CNT_W'(T_INIT);
         S_START_L: len = CNT_W'(T_START_L);
         S_START_H: len = CNT_W'(T_START_H);
         S_BIT_L:   len = cur_bit ? CNT_W'(T_ONE_L) : CNT_W'(T_ZERO_L);
         S_BIT_H:   len = cur_bit ? CNT_W'(T_ONE_H) : CNT_W'(T_ZERO_H);
         S_REL:     len = CNT_W'(T_REL);
         default:   len = CNT_W'(1);
      endcase
   end

   assign cnt_last = (cnt_q == len - CNT_W'(1));

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q + CNT_W'(1);
      bit_idx_d      = bit_idx_q;
      data_d         = data_q;
      rst_req_d      = rst_req_q;
      presence_d     = presence_q;
      presence_err_d = presence_err_q;
      rx_bit_d       = rx_bit_q;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (din_valid) begin
               data_d         = din;
               rst_req_d      = rst_req;
               presence_d     = 1'b0;
               presence_err_d = 1'b0;
               rx_bit_d       = 1'b0;
               state_d        = rst_req ? S_RST_L : S_INIT_H;
            end
         end
         S_RST_L:   if (cnt_last) begin cnt_d = '0; state_d = S_PD_WAIT; end
         S_PD_WAIT: if (cnt_last) begin cnt_d = '0; state_d = S_PD_WIN; end
         S_PD_WIN: begin
            // The last window cycle counts too, so decide on the updated flag.
            if (rst_req_q && !b2s_din) presence_d = 1'b1;
            if (cnt_last) begin
               cnt_d = '0;
               if (presence_d) begin
                  state_d = S_RECOV;
               end else begin
                  presence_err_d = 1'b1;
                  state_d        = S_DONE;
               end
            end
         end
         S_RECOV:   if (cnt_last) begin cnt_d = '0; state_d = S_INIT_H; end
         S_INIT_H:  if (cnt_last) begin cnt_d = '0; state_d = S_START_L; end
         S_START_L: if (cnt_last) begin cnt_d = '0; state_d = S_START_H; end
         S_START_H: begin
            if (cnt_last) begin
               cnt_d     = '0;
               bit_idx_d = FIRST_IDX;
               state_d   = S_BIT_L;
            end
         end
         S_BIT_L:   if (cnt_last) begin cnt_d = '0; state_d = S_BIT_H; end
         S_BIT_H: begin
            if (cnt_last) begin
               cnt_d = '0;
               if (bit_idx_q == LAST_IDX) begin
                  state_d = S_REL;
               end else begin
                  bit_idx_d = (MSB_FIRST != 0) ? bit_idx_q - BW'(1) : bit_idx_q + BW'(1);
                  state_d   = S_BIT_L;
               end
            end
         end
         S_REL: begin
            if (cnt_q == CNT_W'(T_SAMP)) rx_bit_d = b2s_din;
            if (cnt_last) begin cnt_d = '0; state_d = S_DONE; end
         end
         S_DONE: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            cnt_d   = '0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         cnt_q          <= '0;
         bit_idx_q      <= '0;
         data_q         <= '0;
         rst_req_q      <= 1'b0;
         presence_q     <= 1'b0;
         presence_err_q <= 1'b0;
         rx_bit_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         bit_idx_q      <= bit_idx_d;
         data_q         <= data_d;
         rst_req_q      <= rst_req_d;
         presence_q     <= presence_d;
         presence_err_q <= presence_err_d;
         rx_bit_q       <= rx_bit_d;
      end
   end

   always_comb begin
      din_ready = (state_q == S_IDLE);
      busy      = (state_q != S_IDLE);
      done      = (state_q == S_DONE);
      b2s_oe    = !((state_q == S_PD_WIN) || (state_q == S_REL));
      b2s_dout  = !((state_q == S_RST_L) || (state_q == S_START_L) || (state_q == S_BIT_L));
   end

   assign presence     = presence_q;
   assign presence_err = presence_err_q;
   assign rx_bit       = rx_bit_q;

endmodule

// File: tb/tb_b2s_tx_gen2.sv
// Directed bench for b2s_tx_gen2: an LSB-first and an MSB-first instance share stimulus,
// and low-pulse widths, frame lengths and status flags are compared to hand-derived values.
module tb_b2s_tx_gen2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] din = 8'h00;
   logic       din_valid = 1'b0;
   logic       rst_req = 1'b0;
   logic       b2s_din = 1'b1;

   logic ready_l, dout_l, oe_l, busy_l, done_l, pres_l, perr_l, rx_l;
   logic ready_m, dout_m, oe_m, busy_m, done_m, pres_m, perr_m, rx_m;

   int n_checks = 0;
   int n_errors = 0;
   int run_l = 0, run_m = 0;
   int wq_l[$], wq_m[$];
   int done_pulses = 0;
   int cyc;
   int snap;

   int e_a5[$]    = '{20, 18, 136, 18, 136, 136, 18, 136, 18};
   int e_lsb1[$]  = '{20, 18, 136, 136, 136, 136, 136, 136, 136};
   int e_msb1[$]  = '{20, 136, 136, 136, 136, 136, 136, 136, 18};
   int e_pa5[$]   = '{1280, 20, 18, 136, 18, 136, 136, 18, 136, 18};
   int e_nopr[$]  = '{1280};

   always #5 clk = ~clk;

   b2s_tx_gen2 #(.WIDTH(8), .MSB_FIRST(0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .rst_req(rst_req),
      .din_ready(ready_l), .b2s_din(b2s_din), .b2s_dout(dout_l), .b2s_oe(oe_l),
      .busy(busy_l), .done(done_l), .presence(pres_l), .presence_err(perr_l), .rx_bit(rx_l)
   );

   b2s_tx_gen2 #(.WIDTH(8), .MSB_FIRST(1)) u_msb (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid), .rst_req(rst_req),
      .din_ready(ready_m), .b2s_din(b2s_din), .b2s_dout(dout_m), .b2s_oe(oe_m),
      .busy(busy_m), .done(done_m), .presence(pres_m), .presence_err(perr_m), .rx_bit(rx_m)
   );

   // Record widths of driven-low pulses on each instance.
   always @(negedge clk) begin
      if (oe_l && !dout_l) run_l++;
      else begin
         if (run_l > 0) wq_l.push_back(run_l);
         run_l = 0;
      end
      if (oe_m && !dout_m) run_m++;
      else begin
         if (run_m > 0) wq_m.push_back(run_m);
         run_m = 0;
      end
      if (done_l) done_pulses++;
   end

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_widths(input string tag, input int got[$], input int exp[$]);
      check({tag, "_n"}, got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         check($sformatf("%s_%0d", tag, i), got[i], exp[i]);
   endtask

   task automatic start_frame(input logic [7:0] d, input logic r);
      @(negedge clk);
      din       = d;
      rst_req   = r;
      din_valid = 1'b1;
      wq_l.delete();
      wq_m.delete();
      @(posedge clk);
   endtask

   // Cycle 0 ends with the accepting edge; returns the cycle in which done is seen.
   task automatic wait_done(output int c);
      bit seen = 1'b0;
      c = 0;
      while (!seen && c < 20000) begin
         @(negedge clk);
         c++;
         if (c == 1) begin
            check("busy_in_frame", busy_l, 1);
            check("ready_in_frame", ready_l, 0);
            check("flags_cleared", {pres_l, perr_l, rx_l}, 0);
         end
         // Noise on din/din_valid mid-frame must be ignored.
         if (c < 40) begin
            din       = 8'($urandom);
            din_valid = c[0];
         end else begin
            din_valid = 1'b0;
         end
         if (done_l) seen = 1'b1;
      end
      check("done_seen", seen, 1);
      check("done_msb_aligned", done_m, 1);
      check("done_oe", oe_l, 1);
      check("done_dout", dout_l, 1);
   endtask

   task automatic pulse_rel(input int n);
      int k = 0;
      while (oe_l !== 1'b0 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      check("rel_found", oe_l, 0);
      repeat (n) @(negedge clk);
      b2s_din = 1'b0;
      @(negedge clk);
      b2s_din = 1'b1;
   endtask

   task automatic pulse_presence();
      int k = 0;
      while (oe_l !== 1'b0 && k < 5000) begin
         @(negedge clk);
         k++;
      end
      check("pdwin_found", oe_l, 0);
      repeat (100) @(negedge clk);
      b2s_din = 1'b0;
      repeat (121) @(negedge clk);
      b2s_din = 1'b1;
   endtask

   task automatic check_idle_after();
      @(negedge clk);
      check("done_one_cycle", done_l, 0);
      check("idle_ready", ready_l, 1);
      check("idle_busy", busy_l, 0);
      check("idle_oe", oe_l, 1);
      check("idle_dout", dout_l, 1);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", ready_l, 1);
      check("rst_dout", dout_l, 1);
      check("rst_oe", oe_l, 1);
      check("rst_busy", busy_l, 0);
      check("rst_done", done_l, 0);
      check("rst_flags", {pres_l, perr_l, rx_l}, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Plain frame, palindromic pattern
      start_frame(8'hA5, 1'b0);
      wait_done(cyc);
      check("len_a5", cyc, 1547);
      check_widths("a5_lsb", wq_l, e_a5);
      check_widths("a5_msb", wq_m, e_a5);
      check("a5_presence", pres_l, 0);
      check("a5_perr", perr_l, 0);
      check("a5_rx", rx_l, 1);
      check_idle_after();
      check("a5_rx_hold", rx_l, 1);

      // Bit order distinguished; line pulled low at REL counter 75
      fork
         begin start_frame(8'h01, 1'b0); wait_done(cyc); end
         pulse_rel(75);
      join
      check("len_01", cyc, 1547);
      check_widths("x01_lsb", wq_l, e_lsb1);
      check_widths("x01_msb", wq_m, e_msb1);
      check("rx_at_75", rx_l, 0);
      check_idle_after();

      // Pulled low at counter 74 only: sample misses it
      fork
         begin start_frame(8'h80, 1'b0); wait_done(cyc); end
         pulse_rel(74);
      join
      check_widths("x80_lsb", wq_l, e_msb1);
      check_widths("x80_msb", wq_m, e_lsb1);
      check("rx_at_74", rx_l, 1);
      check_idle_after();

      // Reset prefix with a responding device
      fork
         begin start_frame(8'hA5, 1'b1); wait_done(cyc); end
         pulse_presence();
      join
      check("len_pres", cyc, 3897);
      check_widths("pres_lsb", wq_l, e_pa5);
      check("pres_presence", pres_l, 1);
      check("pres_perr", perr_l, 0);
      check_idle_after();

      // Reset prefix, nobody answers
      start_frame(8'h3C, 1'b1);
      wait_done(cyc);
      check("len_nopres", cyc, 1751);
      check_widths("nopres_lsb", wq_l, e_nopr);
      check("nopres_presence", pres_l, 0);
      check("nopres_perr", perr_l, 1);
      check_idle_after();
      check("nopres_perr_hold", perr_l, 1);

      // Reset during bit 3 with din_valid held high
      start_frame(8'hA5, 1'b0);
      repeat (600) @(negedge clk);
      snap  = done_pulses;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_ready", ready_l, 1);
      check("mid_rst_busy", busy_l, 0);
      check("mid_rst_dout", dout_l, 1);
      check("mid_rst_oe", oe_l, 1);
      check("mid_rst_done", done_l, 0);
      repeat (2) @(negedge clk);
      check("mid_rst_no_done", done_pulses, snap);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_accept_busy", busy_l, 1);
      check("mid_rst_accept_ready", ready_l, 0);
      wq_l.delete();
      wq_m.delete();
      wait_done(cyc);
      check("len_after_rst", cyc, 1547);
      check_widths("after_rst_lsb", wq_l, e_a5);
      check_idle_after();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
